// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain controller.
//   state_e   : controller FSM states
//   cnt_width : width of the shift counter for a given chain length
package scan_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // The counter must be able to hold CHAIN_LEN.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Bundle between the test-access side (master) and the scan chain
// controller (slave).
//   pattern_*        : parallel pattern handshake into the controller
//   capture_i        : request one functional capture after the shift
//   scan_en_o/scan_d_o/scan_q_i : serial connection to the scan chain
//   resp_*           : parallel response handshake out of the controller
//   busy_o           : controller is not idle
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic [CHAIN_LEN-1:0] pattern_i;
    logic                 capture_i;
    logic                 pattern_valid_i;
    logic                 pattern_ready_o;
    logic                 scan_en_o;
    logic                 scan_d_o;
    logic                 scan_q_i;
    logic [CHAIN_LEN-1:0] resp_o;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic                 busy_o;

    modport master (
        output pattern_i, capture_i, pattern_valid_i, resp_ready_i, scan_q_i,
        input  pattern_ready_o, scan_en_o, scan_d_o, resp_o, resp_valid_o, busy_o
    );

    modport slave (
        input  pattern_i, capture_i, pattern_valid_i, resp_ready_i, scan_q_i,
        output pattern_ready_o, scan_en_o, scan_d_o, resp_o, resp_valid_o, busy_o
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: accepts a parallel pattern, shifts it MSB first
// into a scan chain, optionally issues one capture cycle, and returns the
// bits shifted out of the chain tail as a parallel response.
//   clk_i  : clock, shared with the chain flops
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of scan_chain_ctrl_if (pattern in, chain, response out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a pattern; chain untouched
// SHIFT   | CHAIN_LEN cycles with scan enable, tail bits collected
// CAPTURE | one cycle with scan enable low so the chain loads functional D
// RESP    | response held valid until accepted
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    scan_chain_ctrl_if.slave bus
);

    localparam int            CW       = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_next;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CW-1:0]        cnt_q;
    logic                 cap_q;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_d_q, scan_d_d;
    logic                 load, shift;

    // Scan outputs are computed one cycle ahead and registered so the
    // chain sees glitch-free levels.
    always_comb begin
        sr_next   = sr_q << 1;
        state_d   = state_q;
        load      = 1'b0;
        shift     = 1'b0;
        scan_en_d = 1'b0;
        scan_d_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pattern_valid_i) begin
                    load      = 1'b1;
                    state_d   = SHIFT;
                    scan_en_d = 1'b1;
                    scan_d_d  = bus.pattern_i[CHAIN_LEN-1];
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = cap_q ? CAPTURE : RESP;
                end else begin
                    scan_en_d = 1'b1;
                    scan_d_d  = sr_next[CHAIN_LEN-1];
                end
            end
            CAPTURE: state_d = RESP;
            RESP: begin
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            scan_en_q <= 1'b0;
            scan_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_en_q <= scan_en_d;
            scan_d_q  <= scan_d_d;
        end
    end

    // Tail bits enter at the LSB and move up, so the first sample ends
    // at bit CHAIN_LEN-1 (the old tail) and the last at bit 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q   <= '0;
            resp_q <= '0;
            cnt_q  <= '0;
            cap_q  <= 1'b0;
        end else if (load) begin
            sr_q   <= bus.pattern_i;
            resp_q <= '0;
            cnt_q  <= '0;
            cap_q  <= bus.capture_i;
        end else if (shift) begin
            sr_q   <= sr_next;
            resp_q <= CHAIN_LEN'({resp_q, bus.scan_q_i});
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign bus.pattern_ready_o = (state_q == IDLE);
    assign bus.resp_valid_o    = (state_q == RESP);
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.scan_en_o       = scan_en_q;
    assign bus.scan_d_o        = scan_d_q;
    assign bus.resp_o          = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;

    logic clk;
    logic rst_n;

    scan_chain_ctrl_if #(.CHAIN_LEN(4)) b4 ();
    scan_chain_ctrl_if #(.CHAIN_LEN(1)) b1 ();

    scan_chain_ctrl #(.CHAIN_LEN(4)) u4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4.slave));
    scan_chain_ctrl #(.CHAIN_LEN(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));

    // Behavioural scan chains: position 0 next to scan_d, tail drives scan_q.
    // When scan enable is low the cells hold, unless functional data is
    // being presented (fen4), in which case they load fval4.
    logic [3:0] ch4;
    logic       ch1;
    logic       fen4;
    logic [3:0] fval4;

    always @(posedge clk) begin
        if (b4.scan_en_o) ch4 <= {ch4[2:0], b4.scan_d_o};
        else if (fen4)    ch4 <= fval4;
        if (b1.scan_en_o) ch1 <= b1.scan_d_o;
    end
    assign b4.scan_q_i = ch4[3];
    assign b1.scan_q_i = ch1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete pattern transaction on the 4-bit controller.
    task automatic run4(input logic [3:0] pat, input logic cap, input logic [3:0] fval,
                        input int hold, input logic early, input logic pulse,
                        input logic [3:0] exp_resp);
        int         n;
        int         gap;
        logic [3:0] sd;
        logic [3:0] r;
        n = 0;
        while (!b4.pattern_ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_load", 32'(b4.pattern_ready_o), 1);
        b4.pattern_i       = pat;
        b4.capture_i       = cap;
        b4.pattern_valid_i = 1'b1;
        if (early) b4.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        b4.pattern_valid_i = 1'b0;
        b4.pattern_i       = 4'($urandom);
        b4.capture_i       = ~cap;
        fen4  = cap;
        fval4 = fval;
        n  = 0;
        sd = '0;
        while (b4.scan_en_o && n < 20) begin
            sd = {sd[2:0], b4.scan_d_o};
            n++;
            @(posedge clk); #1;
        end
        chk("shift_len", n, 4);
        chk("scan_d_seq", 32'(sd), 32'(pat));
        chk("scan_d_after_shift", 32'(b4.scan_d_o), 0);
        gap = 0;
        while (!b4.resp_valid_o && gap < 20) begin
            gap++;
            @(posedge clk); #1;
        end
        fen4 = 1'b0;
        chk("capture_gap", gap, 32'(cap));
        chk("resp_valid", 32'(b4.resp_valid_o), 1);
        chk("ready_in_resp", 32'(b4.pattern_ready_o), 0);
        chk("busy_in_resp", 32'(b4.busy_o), 1);
        r = b4.resp_o;
        chk("resp", 32'(r), 32'(exp_resp));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                if (pulse) b4.pattern_valid_i = (h >= 1 && h < 3);
                @(posedge clk); #1;
                chk("hold_valid", 32'(b4.resp_valid_o), 1);
                chk("hold_data", 32'(b4.resp_o), 32'(r));
                chk("hold_ready", 32'(b4.pattern_ready_o), 0);
            end
        end
        b4.pattern_valid_i = 1'b0;
        b4.resp_ready_i    = 1'b1;
        @(posedge clk); #1;
        b4.resp_ready_i = 1'b0;
        chk("idle_ready", 32'(b4.pattern_ready_o), 1);
        chk("idle_busy", 32'(b4.busy_o), 0);
        chk("idle_resp_valid", 32'(b4.resp_valid_o), 0);
        chk("idle_scan_en", 32'(b4.scan_en_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gold;
        logic [3:0] snap;
        logic [3:0] pat;
        logic [3:0] fv;
        logic       cap;
        logic       early;
        logic       prev1;

        rst_n = 1'b0;
        ch4 = '0; ch1 = 1'b0; fen4 = 1'b0; fval4 = '0;
        b4.pattern_i = '0; b4.capture_i = 1'b0; b4.pattern_valid_i = 1'b0; b4.resp_ready_i = 1'b0;
        b1.pattern_i = '0; b1.capture_i = 1'b0; b1.pattern_valid_i = 1'b0; b1.resp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(b4.pattern_ready_o), 1);
        chk("rst_scan_en", 32'(b4.scan_en_o), 0);
        chk("rst_scan_d", 32'(b4.scan_d_o), 0);
        chk("rst_resp_valid", 32'(b4.resp_valid_o), 0);
        chk("rst_resp", 32'(b4.resp_o), 0);
        chk("rst_busy", 32'(b4.busy_o), 0);
        chk("rst1_ready", 32'(b1.pattern_ready_o), 1);
        chk("rst1_scan_en", 32'(b1.scan_en_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed plan: two plain loads, capture then readout, held response,
        // response ready already high on entry.
        run4(4'b1011, 1'b0, 4'h0, 0, 1'b0, 1'b0, 4'b0000);
        chk("chain_after_1011", 32'(ch4), 32'hB);
        run4(4'b0110, 1'b0, 4'h0, 0, 1'b0, 1'b0, 4'b1011);
        chk("chain_after_0110", 32'(ch4), 32'h6);
        run4(4'b0000, 1'b1, 4'b1111, 0, 1'b0, 1'b0, 4'b0110);
        chk("chain_after_capture", 32'(ch4), 32'hF);
        run4(4'b0000, 1'b0, 4'h0, 5, 1'b0, 1'b1, 4'b1111);
        chk("chain_after_0000", 32'(ch4), 32'h0);
        run4(4'b1100, 1'b0, 4'h0, 0, 1'b1, 1'b0, 4'b0000);
        gold = 4'b1100;

        // Reset during the third shift cycle.
        b4.pattern_i = 4'b1001; b4.capture_i = 1'b0; b4.pattern_valid_i = 1'b1;
        @(posedge clk); #1;
        b4.pattern_valid_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_scan_en", 32'(b4.scan_en_o), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_scan_en", 32'(b4.scan_en_o), 0);
        chk("midrst_scan_d", 32'(b4.scan_d_o), 0);
        chk("midrst_busy", 32'(b4.busy_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", 32'(b4.pattern_ready_o), 1);
        chk("postrst_resp_valid", 32'(b4.resp_valid_o), 0);
        chk("postrst_resp", 32'(b4.resp_o), 0);
        snap = ch4;
        run4(4'b0101, 1'b0, 4'h0, 0, 1'b0, 1'b0, snap);
        gold = 4'b0101;
        chk("chain_after_rst_load", 32'(ch4), 32'(gold));

        // Random transactions: the response is whatever the chain held, and
        // the chain ends up with either the pattern or the functional data.
        for (int t = 0; t < 25; t++) begin
            pat   = 4'($urandom_range(0, 15));
            cap   = 1'($urandom_range(0, 1));
            fv    = 4'($urandom_range(0, 15));
            early = ($urandom_range(0, 3) == 0);
            run4(pat, cap, fv, int'($urandom_range(0, 3)), early, 1'($urandom_range(0, 1)), gold);
            gold = cap ? fv : pat;
            chk("rand_chain", 32'(ch4), 32'(gold));
        end

        // Single-flop chain: pattern 1 twice.
        prev1 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            chk("n1_ready", 32'(b1.pattern_ready_o), 1);
            b1.pattern_i = 1'b1; b1.capture_i = 1'b0; b1.pattern_valid_i = 1'b1;
            @(posedge clk); #1;
            b1.pattern_valid_i = 1'b0;
            chk("n1_scan_en", 32'(b1.scan_en_o), 1);
            chk("n1_scan_d", 32'(b1.scan_d_o), 1);
            @(posedge clk); #1;
            chk("n1_scan_en_off", 32'(b1.scan_en_o), 0);
            chk("n1_resp_valid", 32'(b1.resp_valid_o), 1);
            chk("n1_resp", 32'(b1.resp_o), 32'(prev1));
            prev1 = 1'b1;
            b1.resp_ready_i = 1'b1;
            @(posedge clk); #1;
            b1.resp_ready_i = 1'b0;
            chk("n1_idle", 32'(b1.pattern_ready_o), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
